// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM pipeline stage: widths, funct3 encodings,
// FSM state type and access-size helpers.
package riscv_mem_pkg;

    localparam int unsigned MEM_XLEN = 32;
    localparam int unsigned MEM_RD_W = 5;
    localparam int unsigned STRB_W   = MEM_XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    // Loads accept the unsigned B/H encodings; stores only know SB/SH and
    // treat every other encoding as a full word.
    function automatic mem_size_t access_size(input logic [2:0] funct3,
                                              input logic       is_load);
        mem_size_t sz;
        sz = SZ_W;
        if (is_load) begin
            case (funct3)
                F3_B, F3_BU: sz = SZ_B;
                F3_H, F3_HU: sz = SZ_H;
                default:     sz = SZ_W;
            endcase
        end else begin
            case (funct3)
                F3_B:    sz = SZ_B;
                F3_H:    sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input mem_size_t  sz,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the data bus.
//   funct3, is_load, addr_lo : access encoding and low address bits
//   store_data -> wstrb_c / wdata_c : lane-replicated store payload
//   rdata      -> load_data_c       : extracted and sign/zero-extended load
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic                is_load,
    input  logic [1:0]          addr_lo,
    input  logic [MEM_XLEN-1:0] store_data,
    input  logic [MEM_XLEN-1:0] rdata,
    output logic [STRB_W-1:0]   wstrb_c,
    output logic [MEM_XLEN-1:0] wdata_c,
    output logic [MEM_XLEN-1:0] load_data_c
);

    mem_size_t   size_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Store side: replicate the datum over every lane, strobe picks the lane.
    always_comb begin
        size_c  = access_size(funct3, is_load);
        wstrb_c = '0;
        wdata_c = '0;
        case (size_c)
            SZ_B: begin
                wstrb_c = 4'b0001 << addr_lo;
                wdata_c = {4{store_data[7:0]}};
            end
            SZ_H: begin
                wstrb_c = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                wstrb_c = 4'b1111;
                wdata_c = store_data;
            end
        endcase
    end

    // Load side: funct3[2] distinguishes the unsigned variants.
    always_comb begin
        byte_c      = '0;
        half_c      = '0;
        load_data_c = '0;
        case (addr_lo)
            2'd0:    byte_c = rdata[7:0];
            2'd1:    byte_c = rdata[15:8];
            2'd2:    byte_c = rdata[23:16];
            default: byte_c = rdata[31:24];
        endcase
        half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size_c)
            SZ_B:    load_data_c = funct3[2] ? {24'd0, byte_c}
                                             : {{24{byte_c[7]}}, byte_c};
            SZ_H:    load_data_c = funct3[2] ? {16'd0, half_c}
                                             : {{16{half_c[15]}}, half_c};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the RV32I pipeline.
//   ex_*     : instruction from the EX/MEM buffer (held while stall=1)
//   stall    : combinational hold request to IF/ID/EX and EX/MEM
//   dmem_*   : registered request / ack handshake to data memory
//   wb_*     : registered MEM/WB boundary
// Build option: define MISALIGN_TRAP_EN to report misaligned H/W accesses
// through wb_excp instead of issuing them on the bus.
module mem_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int unsigned XLEN = MEM_XLEN,
    parameter int unsigned RD_W = MEM_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_reg_write,
    input  logic [RD_W-1:0] ex_rd,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_reg_write,
    output logic            wb_excp
);

    mem_state_t      state_q, state_d;

    // Private copy of the in-flight access; the EX/MEM buffer is not trusted.
    logic [2:0]      lat_funct3_q, lat_funct3_d;
    logic [1:0]      lat_addr_lo_q, lat_addr_lo_d;
    logic [RD_W-1:0] lat_rd_q, lat_rd_d;
    logic            lat_reg_write_q, lat_reg_write_d;
    logic            lat_is_load_q, lat_is_load_d;

    logic            dmem_req_d, dmem_we_d;
    logic [XLEN-1:0] dmem_addr_d, dmem_wdata_d;
    logic [3:0]      dmem_wstrb_d;
    logic            wb_valid_d, wb_reg_write_d;
    logic [XLEN-1:0] wb_data_d;
    logic [RD_W-1:0] wb_rd_d;
    logic            stall_c;

    logic            ex_is_mem_c;
    logic [2:0]      align_funct3_c;
    logic            align_is_load_c;
    logic [1:0]      align_addr_lo_c;
    logic [3:0]      wstrb_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] load_data_c;

`ifdef MISALIGN_TRAP_EN
    logic            wb_excp_d;
    logic            misaligned_c;
    assign misaligned_c = is_misaligned(access_size(ex_funct3, ex_mem_read),
                                        ex_alu_res[1:0]);
`endif

    assign ex_is_mem_c = ex_mem_read | ex_mem_write;

    // The single aligner serves the store path in IDLE and the load path in BUS.
    always_comb begin
        align_funct3_c  = ex_funct3;
        align_is_load_c = ex_mem_read;
        align_addr_lo_c = ex_alu_res[1:0];
        if (state_q == BUS) begin
            align_funct3_c  = lat_funct3_q;
            align_is_load_c = lat_is_load_q;
            align_addr_lo_c = lat_addr_lo_q;
        end
    end

    mem_lane_align u_lane_align (
        .funct3      (align_funct3_c),
        .is_load     (align_is_load_c),
        .addr_lo     (align_addr_lo_c),
        .store_data  (ex_store_data),
        .rdata       (dmem_rdata),
        .wstrb_c     (wstrb_c),
        .wdata_c     (wdata_c),
        .load_data_c (load_data_c)
    );

    // Next-state, next-output and stall logic.
    always_comb begin
        state_d         = state_q;
        lat_funct3_d    = lat_funct3_q;
        lat_addr_lo_d   = lat_addr_lo_q;
        lat_rd_d        = lat_rd_q;
        lat_reg_write_d = lat_reg_write_q;
        lat_is_load_d   = lat_is_load_q;
        dmem_req_d      = dmem_req;
        dmem_we_d       = dmem_we;
        dmem_addr_d     = dmem_addr;
        dmem_wdata_d    = dmem_wdata;
        dmem_wstrb_d    = dmem_wstrb;
        wb_valid_d      = 1'b0;
        wb_reg_write_d  = 1'b0;
        wb_data_d       = wb_data;
        wb_rd_d         = wb_rd;
        stall_c         = 1'b0;
`ifdef MISALIGN_TRAP_EN
        wb_excp_d       = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_is_mem_c) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_res;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_reg_write;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (misaligned_c) begin
                        // Faulting address goes to writeback; no bus cycle.
                        wb_valid_d = 1'b1;
                        wb_excp_d  = 1'b1;
                        wb_data_d  = ex_alu_res;
                        wb_rd_d    = ex_rd;
                    end
`endif
                    else begin
                        stall_c         = 1'b1;
                        lat_funct3_d    = ex_funct3;
                        lat_addr_lo_d   = ex_alu_res[1:0];
                        lat_rd_d        = ex_rd;
                        lat_reg_write_d = ex_reg_write;
                        lat_is_load_d   = ex_mem_read;
                        dmem_req_d      = 1'b1;
                        dmem_we_d       = ~ex_mem_read;
                        dmem_addr_d     = {ex_alu_res[XLEN-1:2], 2'b00};
                        dmem_wdata_d    = ex_mem_read ? '0 : wdata_c;
                        dmem_wstrb_d    = ex_mem_read ? 4'b0000 : wstrb_c;
                        state_d         = BUS;
                    end
                end
            end
            BUS: begin
                stall_c = ~dmem_ack;
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = lat_rd_q;
                    if (lat_is_load_q) begin
                        wb_data_d      = load_data_c;
                        wb_reg_write_d = lat_reg_write_q;
                    end else begin
                        wb_data_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall is masked during reset so upstream never freezes on stale state.
    assign stall = stall_c & rst;

    // State, latched access and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            lat_funct3_q    <= '0;
            lat_addr_lo_q   <= '0;
            lat_rd_q        <= '0;
            lat_reg_write_q <= 1'b0;
            lat_is_load_q   <= 1'b0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_wstrb      <= '0;
            wb_valid        <= 1'b0;
            wb_data         <= '0;
            wb_rd           <= '0;
            wb_reg_write    <= 1'b0;
        end else begin
            state_q         <= state_d;
            lat_funct3_q    <= lat_funct3_d;
            lat_addr_lo_q   <= lat_addr_lo_d;
            lat_rd_q        <= lat_rd_d;
            lat_reg_write_q <= lat_reg_write_d;
            lat_is_load_q   <= lat_is_load_d;
            dmem_req        <= dmem_req_d;
            dmem_we         <= dmem_we_d;
            dmem_addr       <= dmem_addr_d;
            dmem_wdata      <= dmem_wdata_d;
            dmem_wstrb      <= dmem_wstrb_d;
            wb_valid        <= wb_valid_d;
            wb_data         <= wb_data_d;
            wb_rd           <= wb_rd_d;
            wb_reg_write    <= wb_reg_write_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_excp <= 1'b0;
        end else begin
            wb_excp <= wb_excp_d;
        end
    end
`else
    assign wb_excp = 1'b0;
`endif

endmodule
